// File: rtl/router_pkg.sv
// Shared router definitions: byte width, reserved address and controller FSM encoding.
package router_pkg;

    localparam int DATA_W = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        decode_address,
        load_first_data,
        load_data,
        fifo_full_state,
        load_after_full,
        load_parity,
        check_parity_error,
        wait_till_empty
    } state_t;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR of header and payload bytes, capture of the packet parity byte,
// and the parity error flag raised one cycle after parity_done rises.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              low_pkt_valid,
    input  logic              parity_done,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] header_byte,
    input  logic [DATA_W-1:0] hold_byte,
    output logic              err
);

    logic [DATA_W-1:0] internal_parity;
    logic [DATA_W-1:0] packet_parity;
    logic              parity_done_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            internal_parity <= '0;
            packet_parity   <= '0;
            parity_done_d   <= 1'b0;
            err             <= 1'b0;
        end else begin
            parity_done_d <= parity_done;

            // A byte held during a stall was already counted in ld_state, so laf adds nothing.
            if (detect_add)
                internal_parity <= '0;
            else if (lfd_state)
                internal_parity <= internal_parity ^ header_byte;
            else if (ld_state && pkt_valid && !full_state)
                internal_parity <= internal_parity ^ data_in;

            if (!detect_add) begin
                if (ld_state && !pkt_valid && !fifo_full)
                    packet_parity <= data_in;
                else if (laf_state && low_pkt_valid && !parity_done)
                    packet_parity <= hold_byte;
            end

            if (detect_add)
                err <= 1'b0;
            else if (parity_done && !parity_done_d)
                err <= (internal_parity != packet_parity);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router register block: header latch, output byte staging across FIFO-full
// stalls, end-of-packet flags and parity check.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err
);

    logic [DATA_W-1:0] header_byte;
    logic [DATA_W-1:0] hold_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            header_byte <= '0;
        end else if (detect_add && pkt_valid && (data_in[1:0] != ADDR_INVALID)) begin
            header_byte <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout      <= '0;
            hold_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            low_pkt_valid <= 1'b0;
        else if (rst_int_reg)
            low_pkt_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_pkt_valid <= 1'b1;
    end

    // Parity byte either lands directly, or was parked in hold_byte and drains on laf.
    always_ff @(posedge clock) begin
        if (reset)
            parity_done <= 1'b0;
        else if (detect_add)
            parity_done <= 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid && !parity_done))
            parity_done <= 1'b1;
    end

    router_parity_chk #(
        .DATA_W(DATA_W)
    ) u_parity_chk (
        .clock        (clock),
        .reset        (reset),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .pkt_valid    (pkt_valid),
        .fifo_full    (fifo_full),
        .low_pkt_valid(low_pkt_valid),
        .parity_done  (parity_done),
        .data_in      (data_in),
        .header_byte  (header_byte),
        .hold_byte    (hold_byte),
        .err          (err)
    );

endmodule
